vram_slave: RTL and testbench

VRAM_SLAVE -- requirements
Module: vram_slave

---
 rtl/vram_slave.sv | 143 ++++++++++++++
 tb/tb_vram_slave.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/vram_slave.sv
// Wishbone-style single-port video RAM slave with byte lanes and a registered read path.
// Optional one-word read-ahead buffer enabled by defining VRAM_PREFETCH_EN.
module vram_slave #(
   parameter int AWIDTH = 12
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        cyc_i,
   input  logic        stb_i,
   input  logic        we_i,
   input  logic [3:0]  sel_i,
   input  logic [31:0] adr_i,
   input  logic [31:0] dat_i,
   output logic [31:0] dat_o,
   output logic        ack_o,
   output logic        err_o
);

   localparam int DEPTH = 1 << AWIDTH;

   typedef enum logic [1:0] {IDLE, RD, ACK, ERR} state_e;

   state_e             state_q, state_d;
   logic [31:0]        dat_q, dat_d;
   logic [31:0]        mem_q [DEPTH];
   logic [31:0]        rd_q;
   logic [AWIDTH-1:0]  idx;
   logic               req, adr_bad, idle_req, wr_en, rd_req, rd_en, hit;

   assign req      = cyc_i & stb_i;
   assign idx      = adr_i[AWIDTH+1:2];
   // Anything above the array or not word-aligned is rejected without touching the RAM.
   assign adr_bad  = ((adr_i >> (AWIDTH + 2)) != '0) || (adr_i[1:0] != 2'b00);
   assign idle_req = (state_q == IDLE) && req;
   assign wr_en    = idle_req && !adr_bad && we_i;
   assign rd_req   = idle_req && !adr_bad && !we_i;
   assign rd_en    = rd_req && !hit;

`ifdef VRAM_PREFETCH_EN
   logic               pf_valid_q, pf_valid_d;
   logic [AWIDTH-1:0]  pf_tag_q, last_q;
   logic [31:0]        pf_data_q;
   logic               rd_ack_q, fill;

   assign hit  = rd_req && pf_valid_q && (pf_tag_q == idx);
   // Fill runs during the ACK cycle of a read, so the buffer is ready by the next IDLE cycle.
   assign fill = (state_q == ACK) && rd_ack_q;

   always_comb begin
      pf_valid_d = pf_valid_q;
      if (idle_req && (adr_bad || we_i))
         pf_valid_d = 1'b0;
      else if (fill)
         pf_valid_d = 1'b1;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         pf_valid_q <= 1'b0;
         pf_tag_q   <= '0;
         rd_ack_q   <= 1'b0;
      end else begin
         pf_valid_q <= pf_valid_d;
         rd_ack_q   <= (state_q == RD && cyc_i) || hit;
         if (fill)
            pf_tag_q <= last_q + AWIDTH'(1);
      end
   end
`else
   assign hit = 1'b0;
`endif

   // NOTE: the array and its read register carry no reset, so they map onto plain RAM.
   always_ff @(posedge clk_i) begin
      if (wr_en) begin
         for (int b = 0; b < 4; b++) begin
            if (sel_i[b])
               mem_q[idx][8*b +: 8] <= dat_i[8*b +: 8];
         end
      end
      if (rd_en)
         rd_q <= mem_q[idx];
`ifdef VRAM_PREFETCH_EN
      if (rd_req)
         last_q <= idx;
      if (fill)
         pf_data_q <= mem_q[last_q + AWIDTH'(1)];
`endif
   end

   // NOTE: sequential state uses non-blocking assignments only; comb blocks use blocking.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         dat_q   <= '0;
      end else begin
         state_q <= state_d;
         dat_q   <= dat_d;
      end
   end

   // NOTE: defaults first so every path assigns state_d and dat_d and no latch is inferred.
   always_comb begin
      state_d = state_q;
      dat_d   = dat_q;
      unique case (state_q)
         IDLE: begin
            if (req) begin
               if (adr_bad)
                  state_d = ERR;
               else if (we_i)
                  state_d = ACK;
`ifdef VRAM_PREFETCH_EN
               else if (hit) begin
                  state_d = ACK;
                  dat_d   = pf_data_q;
               end
`endif
               else
                  state_d = RD;
            end
         end
         RD: begin
            if (!cyc_i)
               state_d = IDLE;
            else begin
               state_d = ACK;
               dat_d   = rd_q;
            end
         end
         ACK:     state_d = IDLE;
         ERR:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      ack_o = (state_q == ACK);
      err_o = (state_q == ERR);
      dat_o = dat_q;
   end

endmodule

// File: tb/tb_vram_slave.sv
// Self-checking bench for vram_slave: directed scenarios plus random traffic against a
// word-array reference model; expected latencies follow VRAM_PREFETCH_EN when defined.
module tb_vram_slave;

   localparam int AW    = 12;
   localparam int WORDS = 1 << AW;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        cyc_i, stb_i, we_i;
   logic [3:0]  sel_i;
   logic [31:0] adr_i, dat_i;
   logic [31:0] dat_o;
   logic        ack_o, err_o;

   int total = 0;
   int bad   = 0;

   // reference model
   logic [31:0] mdl [WORDS];
   logic [31:0] exp_dat;
   bit          pf_valid;
   int          pf_word;

   vram_slave #(.AWIDTH(AW)) dut (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .cyc_i (cyc_i),
      .stb_i (stb_i),
      .we_i  (we_i),
      .sel_i (sel_i),
      .adr_i (adr_i),
      .dat_i (dat_i),
      .dat_o (dat_o),
      .ack_o (ack_o),
      .err_o (err_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s obs=%08h exp=%08h", tag, obs, exp);
      end
   endtask

   // One transfer, issued at a negedge with the DUT idle; returns at a negedge with the DUT idle.
   task automatic txn(input string tag, input logic we, input logic [3:0] sel,
                      input logic [31:0] adr, input logic [31:0] dat);
      int          w;
      int          lat, exp_lat;
      logic [1:0]  outc, exp_outc;
      bit          is_bad;
      w      = int'(adr[AW+1:2]);
      is_bad = (adr[31:AW+2] != 0) || (adr[1:0] != 0);
      if (is_bad) begin
         exp_outc = 2'b10; exp_lat = 1; pf_valid = 0;
      end else if (we) begin
         exp_outc = 2'b01; exp_lat = 1; pf_valid = 0;
         for (int b = 0; b < 4; b++)
            if (sel[b]) mdl[w][8*b +: 8] = dat[8*b +: 8];
      end else begin
         exp_outc = 2'b01;
`ifdef VRAM_PREFETCH_EN
         exp_lat = (pf_valid && pf_word == w) ? 1 : 2;
`else
         exp_lat = 2;
`endif
         exp_dat  = mdl[w];
         pf_valid = 1;
         pf_word  = (w + 1) % WORDS;
      end
      cyc_i = 1; stb_i = 1; we_i = we; sel_i = sel; adr_i = adr; dat_i = dat;
      lat = 0; outc = 2'b00;
      for (int c = 1; c <= 6; c++) begin
         @(posedge clk_i);
         @(negedge clk_i);
         if (ack_o || err_o) begin
            lat  = c;
            outc = {err_o, ack_o};
            break;
         end
      end
      cyc_i = 0; stb_i = 0; we_i = 0;
      chk({tag, ".outcome"}, 32'(outc), 32'(exp_outc));
      chk({tag, ".latency"}, 32'(lat), 32'(exp_lat));
      chk({tag, ".dat_o"}, dat_o, exp_dat);
      @(negedge clk_i);
      chk({tag, ".pulse"}, 32'({ack_o, err_o}), 32'd0);
   endtask

   initial begin
      logic [31:0] adr, dat;
      int          w, prev_w, r;
      bit          seen;

      rst_i = 1; cyc_i = 0; stb_i = 0; we_i = 0; sel_i = 0; adr_i = 0; dat_i = 0;
      exp_dat = 0; pf_valid = 0; pf_word = 0;
      #12;
      chk("reset.ack", 32'(ack_o), 32'd0);
      chk("reset.err", 32'(err_o), 32'd0);
      chk("reset.dat", dat_o, 32'd0);
      @(negedge clk_i);
      rst_i = 0;
      @(negedge clk_i);

      // full write then read back
      txn("wr14", 1, 4'hF, 32'h14, 32'hDEADBEEF);
      txn("rd14", 0, 4'h0, 32'h14, 32'h0);
      // single byte lane write
      txn("wr14b1", 1, 4'h2, 32'h14, 32'h0000AA00);
      txn("rd14b1", 0, 4'h0, 32'h14, 32'h0);
      // out of range and misaligned
      txn("err4000", 0, 4'h0, 32'h0000_4000, 32'h0);
      txn("err15", 0, 4'h0, 32'h15, 32'h0);
      // sel=0 write leaves the word alone
      txn("wr14sel0", 1, 4'h0, 32'h14, 32'h12345678);
      txn("rd14sel0", 0, 4'h0, 32'h14, 32'h0);

      // abort in RD: write first so the read is not a buffer hit
      txn("wr18", 1, 4'hF, 32'h18, 32'hCAFEF00D);
      cyc_i = 1; stb_i = 1; we_i = 0; sel_i = 4'h0; adr_i = 32'h14;
      @(posedge clk_i);
      @(negedge clk_i);
      cyc_i = 0;
      seen = 0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk_i);
         if (ack_o) seen = 1;
      end
      stb_i = 0;
      chk("abort.noack", 32'(seen), 32'd0);
      chk("abort.dat", dat_o, exp_dat);
      txn("wr0", 1, 4'hF, 32'h0, 32'h0BADC0DE);

      // sequential reads, wrap, and a write in between
      txn("wr3ffc", 1, 4'hF, 32'h3FFC, 32'h7777_1111);
      txn("seq.rd14", 0, 4'h0, 32'h14, 32'h0);
      txn("seq.rd18", 0, 4'h0, 32'h18, 32'h0);
      txn("wrap.rd3ffc", 0, 4'h0, 32'h3FFC, 32'h0);
      txn("wrap.rd0", 0, 4'h0, 32'h0, 32'h0);
      txn("miss.rd14", 0, 4'h0, 32'h14, 32'h0);
      txn("miss.wr40", 1, 4'hF, 32'h40, 32'h4040_4040);
      txn("miss.rd18", 0, 4'h0, 32'h18, 32'h0);

      // random traffic over words 0..63 plus the top word
      for (int i = 0; i < 64; i++)
         txn("init", 1, 4'hF, 32'(i) << 2, $urandom());
      txn("init.top", 1, 4'hF, 32'h3FFC, $urandom());
      prev_w = 0;
      for (int i = 0; i < 200; i++) begin
         r = $urandom_range(0, 9);
         w = ($urandom_range(0, 1) == 1) ? ((prev_w + 1) & 63) : $urandom_range(0, 63);
         if ($urandom_range(0, 15) == 0) w = WORDS - 1;
         if (r == 0) begin
            adr = ($urandom_range(0, 1) == 1) ? ((32'(w) << 2) | 32'($urandom_range(1, 3)))
                                              : ($urandom() | 32'h0000_4000);
            txn("rnd.err", 0, 4'h0, adr, 32'h0);
         end else if (r <= 3) begin
            dat = $urandom();
            txn("rnd.wr", 1, 4'($urandom_range(0, 15)), 32'(w) << 2, dat);
         end else begin
            txn("rnd.rd", 0, 4'h0, 32'(w) << 2, 32'h0);
            prev_w = w;
         end
      end

      // reset during RD: write first so the read is a miss
      txn("prerst.wr", 1, 4'hF, 32'h20, 32'hA5A5_5A5A);
      cyc_i = 1; stb_i = 1; we_i = 0; sel_i = 4'h0; adr_i = 32'h20;
      @(posedge clk_i);
      @(negedge clk_i);
      rst_i = 1;
      #1;
      chk("rstrd.ack", 32'(ack_o), 32'd0);
      chk("rstrd.err", 32'(err_o), 32'd0);
      chk("rstrd.dat", dat_o, 32'd0);
      cyc_i = 0; stb_i = 0;
      exp_dat = 0; pf_valid = 0;
      @(negedge clk_i);
      rst_i = 0;
      seen = 0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk_i);
         if (ack_o || err_o) seen = 1;
      end
      chk("rstrd.noack", 32'(seen), 32'd0);
      txn("postrst.rd", 0, 4'h0, 32'h20, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
